// File: rtl/tc_stack_if.sv
// rtl/tc_stack_if.sv - strobe/data/status bundle between a tc_stack and its driver
//
// Purpose: groups the load/save strobe contract, push data, popped value and
//          occupancy/status flags of tc_stack into one port.
// Modports:
//   master : drives load, save, in; observes out, count, empty, full, overflow, underflow
//   slave  : the stack side (tc_stack itself)
// Signals:
//   load      pop request
//   save      push request
//   in        push data, BIT_WIDTH
//   out       registered popped value, BIT_WIDTH
//   count     occupancy 0..DEPTH, $clog2(DEPTH+1)
//   empty     count == 0
//   full      count == DEPTH
//   overflow  sticky push-when-full
//   underflow sticky pop-when-empty

interface tc_stack_if #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 load;
  logic                 save;
  logic [BIT_WIDTH-1:0] in;
  logic [BIT_WIDTH-1:0] out;
  logic [CW-1:0]        count;
  logic                 empty;
  logic                 full;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output load, save, in,
    input  out, count, empty, full, overflow, underflow
  );

  modport slave (
    input  load, save, in,
    output out, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/tc_stack.sv
// rtl/tc_stack.sv - LIFO stage with register-style load/save strobes
//
// Purpose: save pushes bus.in, load pops the top entry onto the registered
//          bus.out; save+load together swaps the top entry. Pointer saturates
//          at 0 and DEPTH, illegal pushes/pops are ignored.
// Ports:
//   clk    in  rising-edge clock for all state
//   rst_n  in  asynchronous active-low reset
//   bus    tc_stack_if.slave (load, save, in -> out, count, empty, full,
//          overflow, underflow)
// Build option: define TC_STACK_ERR_EN to enable the sticky overflow and
//          underflow flags; otherwise both are tied low.

module tc_stack #(
  parameter int UUID      = 0,
  parameter     NAME      = "",
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  tc_stack_if.slave  bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

  logic [BIT_WIDTH-1:0] r_mem [DEPTH];
  logic [BIT_WIDTH-1:0] r_out;
  logic [CW-1:0]        r_count;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_swap;
  logic                 w_we;
  logic [AW-1:0]        w_top_idx;
  logic [AW-1:0]        w_wr_idx;
  logic [BIT_WIDTH-1:0] w_rd_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_push  = bus.save & ~bus.load;
  assign w_swap  = bus.save & bus.load;

  // Low AW bits of count minus one: wraps DEPTH -> DEPTH-1 correctly when full.
  assign w_top_idx = r_count[AW-1:0] - AW'(1);
  assign w_rd_data = r_mem[w_top_idx];

  // Swap on a non-empty stack overwrites the top; every other write lands at
  // sp, which for an empty swap is slot 0.
  assign w_we     = (w_push & ~w_full) | w_swap;
  assign w_wr_idx = (w_swap & ~w_empty) ? w_top_idx : r_count[AW-1:0];

  // Storage is not reset; gating with rst_n keeps a reset edge from writing.
  always_ff @(posedge clk) begin
    if (rst_n && w_we) begin
      r_mem[w_wr_idx] <= bus.in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_count <= '0;
    end else begin
      case ({bus.save, bus.load})
        2'b10: begin
          if (!w_full) r_count <= r_count + CW'(1);
        end
        2'b01: begin
          if (!w_empty) begin
            r_out   <= w_rd_data;
            r_count <= r_count - CW'(1);
          end else begin
            r_out   <= '0;
          end
        end
        2'b11: begin
          // Read uses the pre-edge top, so the old value leaves as the new one lands.
          if (!w_empty) begin
            r_out   <= w_rd_data;
          end else begin
            r_out   <= '0;
            r_count <= CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TC_STACK_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push && w_full)                    r_overflow  <= 1'b1;
      if (bus.load && !bus.save && w_empty)    r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.out   = r_out;
  assign bus.count = r_count;
  assign bus.empty = w_empty;
  assign bus.full  = w_full;
endmodule

// File: tb/tb_tc_stack.sv
// tb/tb_tc_stack.sv - directed table-driven bench for tc_stack

module tb_tc_stack;
  localparam int BW = 8;
  localparam int DP = 16;
`ifdef TC_STACK_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  tc_stack_if #(.BIT_WIDTH(BW), .DEPTH(DP)) bus ();

  tc_stack #(.UUID(0), .NAME("tb"), .BIT_WIDTH(BW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       sv;
    logic [7:0] din;
    logic [7:0] e_out;
    logic [4:0] e_cnt;
    logic       e_empty;
    logic       e_full;
    logic       e_udf;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] e_out, input logic [4:0] e_cnt,
                         input logic e_empty, input logic e_full, input logic e_ovf,
                         input logic e_udf);
    chk({nm, ".out"},       32'(bus.out),       32'(e_out));
    chk({nm, ".count"},     32'(bus.count),     32'(e_cnt));
    chk({nm, ".empty"},     32'(bus.empty),     32'(e_empty));
    chk({nm, ".full"},      32'(bus.full),      32'(e_full));
    chk({nm, ".overflow"},  32'(bus.overflow),  32'(e_ovf));
    chk({nm, ".underflow"}, 32'(bus.underflow), 32'(e_udf));
  endtask

  // Apply one strobe cycle: inputs change on negedge, outputs sampled 1ns after posedge.
  task automatic step(input logic ld, input logic sv, input logic [7:0] d);
    @(negedge clk);
    bus.load = ld;
    bus.save = sv;
    bus.in   = d;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    bus.save = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.load = 1'b0;
    bus.save = 1'b0;
    bus.in   = '0;

    //            ld    sv    din    out    cnt    empty full  udf
    tbl[0]  = '{1'b0, 1'b1, 8'h11, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h22, 8'h00, 5'd2, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h33, 8'h00, 5'd3, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 8'h33, 5'd2, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 8'h11, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h05, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h09, 8'h05, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 8'h09, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'hEE, 8'h09, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, ERR};
    tbl[11] = '{1'b1, 1'b1, 8'h77, 8'h00, 5'd1, 1'b0, 1'b0, ERR};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 8'h77, 5'd0, 1'b1, 1'b0, ERR};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reset_release", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // LIFO order, swap, empty pop, empty swap
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ld, tbl[i].sv, tbl[i].din);
      chk_all($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_cnt, tbl[i].e_empty,
              tbl[i].e_full, 1'b0, tbl[i].e_udf);
    end

    // Asynchronous reset mid-cycle takes effect before the next edge
    step(1'b0, 1'b1, 8'h12);
    step(1'b0, 1'b1, 8'h34);
    step(1'b1, 1'b0, 8'h00);
    chk_all("pre_async", 8'h34, 5'd1, 1'b0, 1'b0, 1'b0, ERR);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to DEPTH, overflow push ignored, top is still the last legal push
    for (int i = 0; i < DP; i++) begin
      step(1'b0, 1'b1, 8'(i));
    end
    chk_all("filled", 8'h00, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hAA);
    chk_all("push_full", 8'h00, 5'd16, 1'b0, 1'b1, ERR, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    chk_all("pop_after_full", 8'h0F, 5'd15, 1'b0, 1'b0, ERR, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    chk_all("pop_after_full2", 8'h0E, 5'd14, 1'b0, 1'b0, ERR, 1'b0);

    // Reset asserted during a pop cycle aborts the pop
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 8'h44);
    step(1'b0, 1'b1, 8'h55);
    @(negedge clk);
    bus.load = 1'b1;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    chk_all("reset_in_pop", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.load = 1'b0;
    rst_n    = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    chk_all("pop_after_reset", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, ERR);
    step(1'b0, 1'b1, 8'h66);
    step(1'b1, 1'b0, 8'h00);
    chk_all("push_pop_after_reset", 8'h66, 5'd0, 1'b1, 1'b0, 1'b0, ERR);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
